// File: rtl/uart_rx_cmd_ctrl.sv
// UART command decoder: turns received byte sequences into register-file, ALU and TX FIFO transactions.
// Optional inter-byte timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic                    TX_WR_EN,
  output logic [DATA_WIDTH-1:0]   TX_WR_DATA,
  input  logic                    TX_FULL,
  output logic                    BUSY
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN,
    ALU_WAIT, SEND_RD, SEND_LSB, SEND_MSB
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [DATA_WIDTH-1:0]   rd_byte, rd_byte_nxt;
  logic [2*DATA_WIDTH-1:0] result, result_nxt;
  logic                    timeout;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;
  logic             timed;

  // Only states waiting on the host for the next byte are time-limited.
  assign timed   = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                   (state == OPA) || (state == OPB) || (state == FUN);
  assign timeout = timed && !RX_D_VLD && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                          cnt <= '0;
    else if (!timed || RX_D_VLD || state_nxt != state) cnt <= '0;
    else                                               cnt <= cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      addr    <= '0;
      rd_byte <= '0;
      result  <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      rd_byte <= rd_byte_nxt;
      result  <= result_nxt;
    end
  end

  // Next state and zero-latency strobes; payloads stay 0 unless their strobe fires.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    rd_byte_nxt = rd_byte;
    result_nxt  = result;
    RF_WrEn     = 1'b0;
    RF_RdEn     = 1'b0;
    RF_Address  = '0;
    RF_WrData   = '0;
    ALU_EN      = 1'b0;
    ALU_FUN     = '0;
    TX_WR_EN    = 1'b0;
    TX_WR_DATA  = '0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:  state_nxt = WR_ADDR;
          CMD_RD:  state_nxt = RD_ADDR;
          CMD_ALU: state_nxt = OPA;
          CMD_FUN: state_nxt = FUN;
          default: state_nxt = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_nxt = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = addr;
        RF_WrData  = RX_P_DATA;
        state_nxt  = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        RF_RdEn    = 1'b1;
        RF_Address = RX_P_DATA[ADDR_WIDTH-1:0];
        state_nxt  = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_VLD) begin
        rd_byte_nxt = RF_RdData;
        state_nxt   = SEND_RD;
      end
      OPA: if (RX_D_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = '0;
        RF_WrData  = RX_P_DATA;
        state_nxt  = OPB;
      end
      OPB: if (RX_D_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = ADDR_WIDTH'(1);
        RF_WrData  = RX_P_DATA;
        state_nxt  = FUN;
      end
      FUN: if (RX_D_VLD) begin
        ALU_EN    = 1'b1;
        ALU_FUN   = RX_P_DATA[3:0];
        state_nxt = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        result_nxt = ALU_OUT;
        state_nxt  = SEND_LSB;
      end
      SEND_RD: if (!TX_FULL) begin
        TX_WR_EN   = 1'b1;
        TX_WR_DATA = rd_byte;
        state_nxt  = IDLE;
      end
      SEND_LSB: if (!TX_FULL) begin
        TX_WR_EN   = 1'b1;
        TX_WR_DATA = result[DATA_WIDTH-1:0];
        state_nxt  = SEND_MSB;
      end
      SEND_MSB: if (!TX_FULL) begin
        TX_WR_EN   = 1'b1;
        TX_WR_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  assign CLK_GATE_EN = (state == FUN) || (state == ALU_WAIT);
  assign BUSY        = (state != IDLE);

endmodule
